// File: rtl/kernel_bc_start_fifo_gen.sv
// First-word fall-through FIFO built on a shift register, with registered
// full/empty/almost flags and sticky overflow/underflow error flags.
module kernel_bc_start_fifo_gen #(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = 3,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_count,
  output logic                  if_almost_full,
  output logic                  if_almost_empty,
  output logic                  ovf_err,
  output logic                  udf_err,
  input  logic                  err_clr
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic                  full_n_q, full_n_d;
  logic                  empty_n_q, empty_n_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  wr_acc, rd_acc;
  logic [CW-1:0]         rd_idx;

  // Acceptance uses the registered flags, so a write at full is rejected
  // even when a read frees a slot in the same cycle.
  assign wr_acc = if_write & if_write_ce & full_n_q;
  assign rd_acc = if_read  & if_read_ce  & empty_n_q;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (wr_acc) begin
      mem_d[0] = if_din;
      for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
    end
  end

  always_comb begin
    count_d = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;

    full_n_d  = (count_d != DEPTH_C);
    empty_n_d = (count_d != '0);
    af_d      = (count_d >= AF_C);
    ae_d      = (count_d <= AE_C);

    // Set beats clear when both happen in the same cycle.
    ovf_d = err_clr ? 1'b0 : ovf_q;
    udf_d = err_clr ? 1'b0 : udf_q;
    if (if_write && if_write_ce && !full_n_q) ovf_d = 1'b1;
    if (if_read  && if_read_ce  && !empty_n_q) udf_d = 1'b1;
  end

  // NOTE: storage is deliberately left out of reset; only the count and flags
  // define validity, and dropping the reset keeps the shift chain plain flops.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // The oldest entry sits at index count-1 since writes shift in at entry 0.
  assign rd_idx = (count_q == '0) ? '0 : count_q - 1'b1;

  always_comb begin
    if_dout = mem_q[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == CW'(i)) if_dout = mem_q[i];
    end
  end

  assign if_count        = count_q;
  assign if_full_n       = full_n_q;
  assign if_empty_n      = empty_n_q;
  assign if_almost_full  = af_q;
  assign if_almost_empty = ae_q;
  assign ovf_err         = ovf_q;
  assign udf_err         = udf_q;

endmodule

// File: tb/tb_kernel_bc_start_fifo_gen.sv
// Directed bench for kernel_bc_start_fifo_gen: a DEPTH=4 instance and a
// non-power-of-two DEPTH=5 instance, both with 8-bit data.
module tb_kernel_bc_start_fifo_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: DEPTH=4, ADDR_WIDTH=2, AF=3, AE=1
  logic       a_reset, a_wce, a_write, a_rce, a_read, a_err_clr;
  logic [7:0] a_din, a_dout;
  logic       a_full_n, a_empty_n, a_af, a_ae, a_ovf, a_udf;
  logic [2:0] a_count;

  kernel_bc_start_fifo_gen #(
    .DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1)
  ) dut_a (
    .clk(clk), .reset(a_reset),
    .if_write_ce(a_wce), .if_write(a_write), .if_din(a_din), .if_full_n(a_full_n),
    .if_read_ce(a_rce), .if_read(a_read), .if_dout(a_dout), .if_empty_n(a_empty_n),
    .if_count(a_count), .if_almost_full(a_af), .if_almost_empty(a_ae),
    .ovf_err(a_ovf), .udf_err(a_udf), .err_clr(a_err_clr)
  );

  // Instance B: DEPTH=5, ADDR_WIDTH=3, AF=4, AE=1
  logic       b_reset, b_wce, b_write, b_rce, b_read, b_err_clr;
  logic [7:0] b_din, b_dout;
  logic       b_full_n, b_empty_n, b_af, b_ae, b_ovf, b_udf;
  logic [3:0] b_count;

  kernel_bc_start_fifo_gen #(
    .DATA_WIDTH(8), .DEPTH(5), .ADDR_WIDTH(3), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut_b (
    .clk(clk), .reset(b_reset),
    .if_write_ce(b_wce), .if_write(b_write), .if_din(b_din), .if_full_n(b_full_n),
    .if_read_ce(b_rce), .if_read(b_read), .if_dout(b_dout), .if_empty_n(b_empty_n),
    .if_count(b_count), .if_almost_full(b_af), .if_almost_empty(b_ae),
    .ovf_err(b_ovf), .udf_err(b_udf), .err_clr(b_err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_write = 1'b0; a_read = 1'b0; a_err_clr = 1'b0; a_reset = 1'b0;
  endtask

  task automatic a_push(input logic [7:0] d);
    a_write = 1'b1; a_din = d;
    step();
    a_idle();
  endtask

  task automatic a_pop(input string tag, input logic [7:0] exp);
    check(tag, a_dout, exp);
    a_read = 1'b1;
    step();
    a_idle();
  endtask

  task automatic b_push(input logic [7:0] d);
    b_write = 1'b1; b_din = d;
    step();
    b_write = 1'b0;
  endtask

  logic [7:0] model_q[$];
  logic [7:0] exp_head;

  initial begin
    a_wce = 1'b1; a_rce = 1'b1; a_din = '0; a_idle(); a_reset = 1'b1;
    b_wce = 1'b1; b_rce = 1'b1; b_din = '0; b_write = 1'b0; b_read = 1'b0;
    b_err_clr = 1'b0; b_reset = 1'b1;
    step(); step();
    a_reset = 1'b0; b_reset = 1'b0;

    // Reset state
    check("rst_count",   a_count,   0);
    check("rst_empty_n", a_empty_n, 0);
    check("rst_full_n",  a_full_n,  1);
    check("rst_ae",      a_ae,      1);
    check("rst_af",      a_af,      0);
    check("rst_ovf",     a_ovf,     0);
    check("rst_udf",     a_udf,     0);

    // Write with clock-enable low is ignored
    a_wce = 1'b0; a_push(8'hEE); a_wce = 1'b1;
    check("wce_off_count", a_count, 0);

    // Fill: first word falls through
    a_push(8'h11);
    check("ff_empty_n", a_empty_n, 1);
    check("ff_dout",    a_dout,    8'h11);
    check("ff_ae_c1",   a_ae,      1);
    a_push(8'h22);
    check("ae_c2",      a_ae,      0);
    a_push(8'h33);
    check("af_c3",      a_af,      1);
    check("full_n_c3",  a_full_n,  1);
    a_push(8'h44);
    check("fill_count", a_count,   4);
    check("fill_full_n", a_full_n, 0);

    // Drain in order
    a_pop("drain_0", 8'h11);
    a_pop("drain_1", 8'h22);
    a_pop("drain_2", 8'h33);
    a_pop("drain_3", 8'h44);
    check("drain_empty_n", a_empty_n, 0);
    check("drain_ae",      a_ae,      1);
    check("drain_count",   a_count,   0);

    // Full with simultaneous read: read wins, write rejected, ovf set
    a_push(8'h11); a_push(8'h22); a_push(8'h33); a_push(8'h44);
    a_write = 1'b1; a_din = 8'h55; a_read = 1'b1;
    step(); a_idle();
    check("fullrw_count",  a_count,  3);
    check("fullrw_ovf",    a_ovf,    1);
    check("fullrw_dout",   a_dout,   8'h22);
    check("fullrw_full_n", a_full_n, 1);
    check("fullrw_udf",    a_udf,    0);

    // Clear ovf, bring to count 2 (C, D)
    a_err_clr = 1'b1; step(); a_idle();
    check("clr_ovf", a_ovf, 0);
    a_pop("pre_stream", 8'h22);
    check("stream_start_count", a_count, 2);

    // Steady stream: read+write each cycle, scoreboard tracks order
    model_q = '{8'h33, 8'h44};
    for (int i = 0; i < 10; i++) begin
      exp_head = model_q.pop_front();
      check("stream_dout", a_dout, exp_head);
      model_q.push_back(8'h60 + 8'(i));
      a_write = 1'b1; a_read = 1'b1; a_din = 8'h60 + 8'(i);
      step(); a_idle();
      check("stream_count", a_count, 2);
    end
    check("stream_ovf", a_ovf, 0);
    check("stream_udf", a_udf, 0);
    exp_head = model_q.pop_front(); a_pop("stream_tail0", exp_head);
    exp_head = model_q.pop_front(); a_pop("stream_tail1", exp_head);
    check("stream_empty_n", a_empty_n, 0);

    // Empty boundary: read ignored, write accepted, udf set
    a_write = 1'b1; a_read = 1'b1; a_din = 8'hA5;
    step(); a_idle();
    check("emptyrw_count", a_count,   1);
    check("emptyrw_dout",  a_dout,    8'hA5);
    check("emptyrw_udf",   a_udf,     1);
    check("emptyrw_empty_n", a_empty_n, 1);
    a_err_clr = 1'b1; step(); a_idle();
    check("clr_udf",       a_udf,     0);
    check("clr_keep_count", a_count,  1);

    // Set takes priority over clear: overflow at full with err_clr
    a_push(8'hB1); a_push(8'hB2); a_push(8'hB3);
    check("prio_full_n", a_full_n, 0);
    a_write = 1'b1; a_din = 8'hC0; a_err_clr = 1'b1;
    step(); a_idle();
    check("prio_ovf",   a_ovf,   1);
    check("prio_count", a_count, 4);
    check("prio_dout",  a_dout,  8'hA5);

    // Reset mid-stream at count 3 with a write pending
    a_pop("pre_rst", 8'hA5);
    check("pre_rst_count", a_count, 3);
    a_reset = 1'b1; a_write = 1'b1; a_din = 8'hDD; a_read = 1'b0;
    step(); a_idle();
    check("mrst_count",   a_count,   0);
    check("mrst_empty_n", a_empty_n, 0);
    check("mrst_full_n",  a_full_n,  1);
    check("mrst_ae",      a_ae,      1);
    check("mrst_af",      a_af,      0);
    check("mrst_ovf",     a_ovf,     0);
    check("mrst_udf",     a_udf,     0);
    step();
    check("mrst_hold_count", a_count, 0);

    // Non-power-of-two depth on instance B
    b_push(8'h01); b_push(8'h02); b_push(8'h03);
    check("b_af_c3", b_af, 0);
    b_push(8'h04);
    check("b_af_c4",     b_af,     1);
    check("b_full_n_c4", b_full_n, 1);
    b_push(8'h05);
    check("b_count_c5",  b_count,  5);
    check("b_full_n_c5", b_full_n, 0);
    b_push(8'h06);
    check("b_rej_count", b_count,  5);
    check("b_rej_ovf",   b_ovf,    1);
    for (int i = 0; i < 5; i++) begin
      check("b_drain", b_dout, 32'(i + 1));
      b_read = 1'b1; step(); b_read = 1'b0;
    end
    check("b_empty_n", b_empty_n, 0);
    check("b_count_0", b_count,   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kernel_bc_start_fifo_gen.md
KERNEL_BC_START_FIFO_GEN -- requirements
Module: kernel_bc_start_fifo_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 1, token/data width in bits, 1..64.
- DEPTH, 4, number of entries, any integer 2..64, not restricted to a power of two.
- ADDR_WIDTH, 2, index width; 2^ADDR_WIDTH >= DEPTH is required.
- AF_LEVEL, 3, almost-full threshold in entries, 1..DEPTH.
- AE_LEVEL, 1, almost-empty threshold in entries, 0..DEPTH-1.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock; all state updates on the rising edge.
- reset, in, 1, synchronous, active-high.
- if_write_ce, in, 1, write clock-enable.
- if_write, in, 1, write request.
- if_din, in, DATA_WIDTH, write data.
- if_full_n, out, 1, high when space is available.
- if_read_ce, in, 1, read clock-enable.
- if_read, in, 1, read request.
- if_dout, out, DATA_WIDTH, head-of-queue data.
- if_empty_n, out, 1, high when data is valid.
- if_count, out, ADDR_WIDTH+1, current occupancy.
- if_almost_full, out, 1, occupancy at or above AF_LEVEL.
- if_almost_empty, out, 1, occupancy at or below AE_LEVEL.
- ovf_err, out, 1, sticky write-when-full flag.
- udf_err, out, 1, sticky read-when-empty flag.
- err_clr, in, 1, clears both sticky error flags.

Function
REQ-003 Write SHALL be accepted when if_write & if_write_ce & if_full_n = 1; read SHALL be accepted when if_read & if_read_ce & if_empty_n = 1.
REQ-004 Storage SHALL be a DEPTH-entry shift register: an accepted write shifts all entries up by one and loads if_din into entry 0; no shift occurs otherwise.
REQ-005 if_count SHALL increment by 1 on write-only, decrement by 1 on read-only, and hold on both or neither.
REQ-006 if_dout SHALL be combinational from entry (if_count-1) when if_count > 0 and from entry 0 when if_count = 0; its value while if_empty_n = 0 is don't-care.
REQ-007 Latency: data written at edge n SHALL appear on if_dout, with if_empty_n = 1, immediately after edge n when the FIFO was empty (first-word fall-through).
REQ-008 if_full_n and if_empty_n SHALL be registered and SHALL equal (next count != DEPTH) and (next count != 0) respectively, updated on the same edge as if_count.
REQ-009 Simultaneous accepted read and write SHALL keep the count unchanged, pop the old head, and present the next-oldest entry on if_dout.
REQ-010 Full boundary: while if_full_n = 0 a write SHALL be rejected even if a read is accepted in the same cycle; only the read takes effect (count DEPTH to DEPTH-1).
REQ-011 Empty boundary: while if_empty_n = 0 a read SHALL be ignored; a simultaneous write SHALL be accepted (count 0 to 1).
REQ-012 if_almost_full SHALL be registered, equal to (count >= AF_LEVEL); if_almost_empty SHALL be registered, equal to (count <= AE_LEVEL); both are based on the post-edge count.
REQ-013 ovf_err SHALL set on any edge where if_write & if_write_ce = 1 and if_full_n = 0; udf_err SHALL set on any edge where if_read & if_read_ce = 1 and if_empty_n = 0.
REQ-014 err_clr = 1 SHALL clear both error flags on the next edge; a set condition in the same cycle SHALL take priority over the clear.
REQ-015 Rejected writes and ignored reads SHALL NOT alter storage, count or flags other than the error flags.
REQ-016 Count arithmetic SHALL be ADDR_WIDTH+1 bits and SHALL never leave the range 0..DEPTH.

Reset
REQ-017 While reset = 1 at an edge, the following SHALL load: if_count = 0, if_empty_n = 0, if_full_n = 1, if_almost_empty = 1, if_almost_full = 0, ovf_err = 0, udf_err = 0.
REQ-018 Reset SHALL take priority over all concurrent read, write and err_clr requests.
REQ-019 Storage contents SHALL NOT be reset; reset asserted mid-operation SHALL discard all queued entries.

Verification
REQ-020 Directed scenarios the bench SHALL cover (defaults, DATA_WIDTH=8):
- Fill/drain: write A,B,C,D -> full_n=0 and count=4 after the 4th edge; read 4 times -> dout A,B,C,D in order, then empty_n=0 and almost_empty=1.
- Full with simultaneous read: at count=4 assert write(E) and read together -> A popped, E rejected, count=3, ovf_err=1.
- Steady stream: at count=2, read and write every cycle for 10 cycles -> count stays 2, output order is preserved, no error flags set.
- Empty boundary: at count=0 assert read and write(X) together -> count=1, dout=X, udf_err=1; err_clr asserted alone -> udf_err=0 on the next edge.
- Non-power-of-two depth: DEPTH=5, ADDR_WIDTH=3, AF_LEVEL=4 -> almost_full=1 at count 4, full_n=0 at count 5, 6th write rejected.
- Reset mid-stream: reset asserted at count=3 with write pending -> count=0, empty_n=0, full_n=1, all flags at reset values, pending write dropped.
